// File: rtl/params_pkg.sv
// ============================================================================
// Module      : params_pkg
// Description : Shared stream parameters and the FIFO storage word type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package params_pkg;

  localparam int AXIS_DATA_WIDTH         = 8;
  localparam int AXIS_FIFO_DEPTH_DEFAULT = 16;

  typedef struct packed {
    logic                       tlast;
    logic [AXIS_DATA_WIDTH-1:0] tdata;
  } axis_beat_t;

endpackage

`default_nettype wire

// File: rtl/axi_stream_if.sv
// ============================================================================
// Module      : axi_stream_if
// Description : Minimal AXI-Stream bundle (tdata/tvalid/tlast/tready).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_stream_if;
  import params_pkg::*;

  logic [AXIS_DATA_WIDTH-1:0] tdata;
  logic                       tvalid;
  logic                       tlast;
  logic                       tready;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/axis_fifo_ram.sv
// ============================================================================
// Module      : axis_fifo_ram
// Description : Simple dual-port beat store, synchronous write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_fifo_ram
  import params_pkg::*;
#(
  parameter  int DEPTH = AXIS_FIFO_DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  axis_beat_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output axis_beat_t    rdata_o
);

  axis_beat_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/axis_ingress_fifo.sv
// ============================================================================
// Module      : axis_ingress_fifo
// Description : FWFT AXI-Stream FIFO with fill level and stored-packet count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_ingress_fifo
  import params_pkg::*;
#(
  parameter  int DEPTH = AXIS_FIFO_DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  axi_stream_if.slave  s_axis,
  axi_stream_if.master m_axis,
  output logic [AW:0]  level,
  output logic [AW:0]  pkt_count,
  output logic         full,
  output logic         empty
);

  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic [AW:0] pkt_count_q, pkt_count_d;
  logic        wr_en, rd_en, wr_last, rd_last;
  axis_beat_t  wr_beat, rd_beat;

  // Extra wrap bit distinguishes full from empty when the low bits match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign s_axis.tready = !full && !reset;
  assign m_axis.tvalid = !empty;
  assign m_axis.tdata  = rd_beat.tdata;
  assign m_axis.tlast  = rd_beat.tlast;

  assign wr_en   = s_axis.tvalid && s_axis.tready;
  assign rd_en   = m_axis.tvalid && m_axis.tready;
  assign wr_last = wr_en && s_axis.tlast;
  assign rd_last = rd_en && rd_beat.tlast;
  assign wr_beat = '{tlast: s_axis.tlast, tdata: s_axis.tdata};

  assign level     = level_q;
  assign pkt_count = pkt_count_q;

  axis_fifo_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_beat),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_beat)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    pkt_count_d = pkt_count_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + ONE;

    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + ONE;
      2'b01:   level_d = level_q - ONE;
      default: level_d = level_q;
    endcase

    case ({wr_last, rd_last})
      2'b10:   pkt_count_d = pkt_count_q + ONE;
      2'b01:   pkt_count_d = pkt_count_q - ONE;
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pkt_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pkt_count_q <= pkt_count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_ingress_fifo.sv
// ============================================================================
// Module      : tb_axis_ingress_fifo
// Description : Directed self-checking bench for axis_ingress_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_ingress_fifo;

  logic       clk;
  logic       reset;
  logic [4:0] level;
  logic [4:0] pkt_count;
  logic       full;
  logic       empty;

  int vectors;
  int miscompares;

  axi_stream_if s_if ();
  axi_stream_if m_if ();

  axis_ingress_fifo #(
    .DEPTH (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .level     (level),
    .pkt_count (pkt_count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and land 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;

    // Reset asserted
    #2;
    check("rst_tready", int'(s_if.tready), 0);
    check("rst_level", int'(level), 0);
    check("rst_mvalid", int'(m_if.tvalid), 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("idle_empty", int'(empty), 1);
    check("idle_full", int'(full), 0);
    check("idle_level", int'(level), 0);
    check("idle_pkt", int'(pkt_count), 0);
    check("idle_mvalid", int'(m_if.tvalid), 0);
    check("idle_tready", int'(s_if.tready), 1);

    // Fill with 0xA0..0xAF, tlast on 0xA3 and 0xAF, output stalled
    for (int i = 0; i < 16; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'(8'hA0 + i);
      s_if.tlast  = (i == 3) || (i == 15);
      tick();
    end
    s_if.tdata = 8'hB0;
    s_if.tlast = 1'b0;
    #1;
    check("fill_level", int'(level), 16);
    check("fill_full", int'(full), 1);
    check("fill_pkt", int'(pkt_count), 2);
    check("fill_tready", int'(s_if.tready), 0);
    check("fill_head", int'(m_if.tdata), 8'hA0);
    tick();
    check("fill_hold_level", int'(level), 16);
    check("fill_hold_data", int'(m_if.tdata), 8'hA0);
    s_if.tvalid = 1'b0;

    // Drain in order
    m_if.tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("drain_valid", int'(m_if.tvalid), 1);
      check("drain_data", int'(m_if.tdata), 8'hA0 + i);
      check("drain_last", int'(m_if.tlast), ((i == 3) || (i == 15)) ? 1 : 0);
      check("drain_level", int'(level), 16 - i);
      tick();
    end
    m_if.tready = 1'b0;
    #1;
    check("drained_level", int'(level), 0);
    check("drained_pkt", int'(pkt_count), 0);
    check("drained_empty", int'(empty), 1);
    check("drained_mvalid", int'(m_if.tvalid), 0);

    // Preload three beats, then stream 100 beats both sides at full rate
    for (int n = 0; n < 3; n++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'(n);
      s_if.tlast  = ((n % 7) == 6);
      tick();
    end
    m_if.tready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      s_if.tdata = 8'(k + 3);
      s_if.tlast = (((k + 3) % 7) == 6);
      #1;
      check("stream_level", int'(level), 3);
      check("stream_data", int'(m_if.tdata), k);
      check("stream_last", int'(m_if.tlast), ((k % 7) == 6) ? 1 : 0);
      tick();
    end
    s_if.tvalid = 1'b0;
    for (int k = 100; k < 103; k++) begin
      #1;
      check("stream_tail", int'(m_if.tdata), k);
      tick();
    end
    m_if.tready = 1'b0;
    #1;
    check("stream_empty", int'(empty), 1);

    // Full with a one-cycle read pulse while the source keeps offering
    for (int i = 0; i < 16; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'(8'hC0 + i);
      s_if.tlast  = 1'b0;
      tick();
    end
    s_if.tdata  = 8'hD0;
    m_if.tready = 1'b1;
    #1;
    check("pulse_tready", int'(s_if.tready), 0);
    tick();
    m_if.tready = 1'b0;
    #1;
    check("pulse_level", int'(level), 15);
    check("pulse_full", int'(full), 0);
    check("pulse_head", int'(m_if.tdata), 8'hC1);
    tick();
    s_if.tvalid = 1'b0;
    #1;
    check("refill_level", int'(level), 16);
    check("refill_full", int'(full), 1);
    m_if.tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("refill_data", int'(m_if.tdata), (i < 15) ? (8'hC1 + i) : 8'hD0);
      tick();
    end
    m_if.tready = 1'b0;

    // One complete packet plus 5 beats of an unfinished one, then async reset
    for (int i = 0; i < 6; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'(8'h5F + i);
      s_if.tlast  = (i == 0);
      tick();
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    #1;
    check("pre_rst_level", int'(level), 6);
    check("pre_rst_pkt", int'(pkt_count), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_level", int'(level), 0);
    check("async_pkt", int'(pkt_count), 0);
    check("async_mvalid", int'(m_if.tvalid), 0);
    check("async_empty", int'(empty), 1);
    check("async_tready", int'(s_if.tready), 0);
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_tready", int'(s_if.tready), 1);
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'h55;
    s_if.tlast  = 1'b1;
    #1;
    check("post_rst_no_bypass", int'(m_if.tvalid), 0);
    tick();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    #1;
    check("post_rst_mvalid", int'(m_if.tvalid), 1);
    check("post_rst_data", int'(m_if.tdata), 8'h55);
    check("post_rst_last", int'(m_if.tlast), 1);
    check("post_rst_level", int'(level), 1);
    check("post_rst_pkt", int'(pkt_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axis_ingress_fifo.md
# axis_ingress_fifo

Parameterised AXI-Stream FIFO that sits directly upstream of `stream_processor`. It accepts beats from the ingress source on `s_axis` and presents them to the processor's slave port on `m_axis`. It absorbs backpressure from the processing path, preserves `tlast` framing, and reports its fill level and how many complete packets it holds. Storage uses first-word-fall-through semantics with a one-cycle write-to-read latency.

## Interface
Parameters:
- `DEPTH`, default 16: number of beat entries. Must be a power of two and at least 2.
- `AW`, default `$clog2(DEPTH)`: pointer width. Derived, not overridden.

Ports:
- `clk` input, 1 bit: single clock; all logic is on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `s_axis` `axi_stream_if.slave`: ingress beats. Carries `tdata` (`AXIS_DATA_WIDTH`), `tvalid`, `tlast`, and `tready` as an output.
- `m_axis` `axi_stream_if.master`: egress to `stream_processor`.
- `level` output, `AW+1` bits: number of beats stored, 0..DEPTH.
- `pkt_count` output, `AW+1` bits: number of stored beats with `tlast=1`.
- `full` output, 1 bit: high when `level == DEPTH`.
- `empty` output, 1 bit: high when `level == 0`.

## Operation
- Write: a beat is written when `s_axis.tvalid && s_axis.tready`.
  - `tdata` and `tlast` go to `mem[wr_ptr]`, then `wr_ptr` increments.
  - `s_axis.tready = !full && !reset`.
- Read: a beat is consumed when `m_axis.tvalid && m_axis.tready`, then `rd_ptr` increments.
  - `m_axis.tvalid = !empty`.
  - `m_axis.tdata` and `m_axis.tlast` are taken from `mem[rd_ptr]`.
- Pointers are `AW+1` bits wide with an extra wrap bit.
  - `empty` is true when the pointers are equal.
  - `full` is true when the MSBs differ and the low `AW` bits are equal.
  - Each pointer wraps from DEPTH-1 to 0 in its low bits.
- `level` is a registered counter:
  - +1 on write only, -1 on read only.
  - Unchanged when a write and a read happen in the same cycle.
- `pkt_count` is a registered counter:
  - +1 on a write with `tlast`, -1 on a read with `tlast`.
  - Unchanged when both happen in the same cycle.
- Full with a simultaneous read: `tready` is 0 in that cycle, so no write is accepted. The freed slot is offered on the next cycle.
- Empty with an incoming write: there is no bypass. The beat appears on `m_axis` in the next cycle.
- Output stability: while `m_axis.tvalid && !m_axis.tready`, `tdata` and `tlast` must hold. This follows from `rd_ptr` being frozen.
- No state machine beyond the pointer and counter logic. No packet dropping and no overflow or underflow are possible by construction.
- Reset:
  - Asserting `reset` at any time, including mid-packet, clears `wr_ptr`, `rd_ptr`, `level` and `pkt_count` immediately and asynchronously.
  - Any partial packet in flight is discarded.
  - Memory contents are not cleared.

## Timing
- Reset values:
  - `level` = 0, `pkt_count` = 0, `full` = 0, `empty` = 1.
  - `m_axis.tvalid` = 0.
  - `s_axis.tready` = 0 while reset is asserted, and 1 in the first cycle after release.
- Latency: a write accepted at edge N makes `m_axis.tvalid` high after edge N, i.e. the beat is visible in cycle N+1.
- Throughput: one beat per cycle in and out when neither side stalls.
- `full`, `empty`, `level` and `pkt_count` all update on the same edge as the pointers.
- All outputs are derived from registers. There is no combinational path from `m_axis.tready` to `s_axis.tready`.

## Structure
- `params_pkg` holds:
  - `AXIS_DATA_WIDTH` (existing).
  - A new `AXIS_FIFO_DEPTH_DEFAULT = 16`.
  - A typedef `axis_beat_t`, a packed struct of `{tlast, tdata}` used as the memory word.
- Sub-module `axis_fifo_ram`:
  - Simple dual-port array of `axis_beat_t`, `DEPTH` entries.
  - Synchronous write and asynchronous read.
  - No reset on the storage.
- Top-level `axis_ingress_fifo` owns the pointers, counters, flags and handshake logic.

## Test plan
- Reset, then idle:
  - Expect `empty=1`, `full=0`, `level=0`, `m_axis.tvalid=0`, `s_axis.tready=1`.
- Write beats 0xA0..0xAF with `tlast` on 0xA3 and 0xAF while `m_axis.tready=0`:
  - Expect `level=16`, `full=1`, `pkt_count=2`, `tready=0`.
- Drain that full FIFO with `m_axis.tready=1`:
  - Expect beats 0xA0..0xAF in order, `tlast` on the 4th and 16th beats.
  - Expect `level` to reach 0, `pkt_count` 0, `empty=1`.
- Run concurrent streaming of 100 beats at full rate on both sides, with the FIFO holding 3 beats:
  - Expect `level` to stay at 3 throughout.
  - Expect the output sequence to equal the input sequence delayed by 3 beats.
- With the FIFO full, pulse `m_axis.tready` for one cycle while `s_axis.tvalid=1`:
  - Expect no write in that cycle, `level` to read 15, and the write accepted in the next cycle with `level` back at 16.
- Write 5 beats of an unfinished packet (no `tlast`), then assert `reset` asynchronously mid-cycle:
  - Expect `level=0`, `pkt_count=0`, `m_axis.tvalid=0` immediately.
  - After release, a new beat 0x55 is the first beat output.
